fp_dot_sequencer: RTL

- Upstream/downstream controller wrapped around the single-precision floating-point MAC stage (a*b+c, AXI-stream style, fixed but unknown latency).
- Accepts a stream of (a,b) operand pairs terminated by a last flag.
- Issues one MAC operation at a time, with c = running accumulator.
- Captures each MAC result and, on the last pair, emits the dot product on an output valid/ready port.

---
 rtl/fp_dot_pkg.sv | 15 +
 rtl/fp_dot_out_reg.sv | 41 ++++
 rtl/fp_dot_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fp_dot_pkg.sv
// fp_dot_pkg: shared types and constants for the dot-product sequencer.
// Optional build macro for the whole slice: FP_DOT_TIMEOUT_EN.
package fp_dot_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h00000000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } state_t;

endpackage

// File: rtl/fp_dot_out_reg.sv
// fp_dot_out_reg: result hold register with valid/ready handshake.
// Holds data and flags stable from load until the consumer accepts.
module fp_dot_out_reg
  import fp_dot_pkg::*;
(
  input  logic            clk,
  input  logic            aresetn,
  input  logic            load,
  input  logic [FP_W-1:0] load_data,
  input  logic            load_trunc,
  input  logic            load_err,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [FP_W-1:0] out_data,
  output logic            out_trunc,
  output logic            out_err,
  output logic            done
);

  assign done = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_data  <= FP_ZERO;
      out_trunc <= 1'b0;
      out_err   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_trunc <= load_trunc;
      out_err   <= load_err;
    end else if (done) begin
      out_valid <= 1'b0;
      out_data  <= FP_ZERO;
      out_trunc <= 1'b0;
      out_err   <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_dot_sequencer.sv
// fp_dot_sequencer: drives a pipelined FP MAC one pair at a time.
// Define FP_DOT_TIMEOUT_EN to bound the wait for each MAC result.
module fp_dot_sequencer
  import fp_dot_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] in_a,
  input  logic [FP_W-1:0] in_b,
  input  logic            in_last,
  output logic            mac_tvalid,
  output logic [FP_W-1:0] mac_a,
  output logic [FP_W-1:0] mac_b,
  output logic [FP_W-1:0] mac_c,
  input  logic            mac_res_tvalid,
  input  logic [FP_W-1:0] mac_res_tdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] out_data,
  output logic            out_trunc,
  output logic            out_err
);

  localparam int CW = $clog2(MAX_LEN + 1);

  state_t          state, next;
  logic [FP_W-1:0] acc;
  logic [CW-1:0]   count;
  logic            last_q;
  logic            rst_done;
  logic            accept;
  logic            done;
  logic            load;
  logic [FP_W-1:0] ld_data;
  logic            ld_trunc;
  logic            ld_err;
  logic            tmo;

  assign in_ready   = (state == IDLE) && rst_done;
  assign accept     = in_valid && in_ready;
  assign mac_tvalid = (state == ISSUE);

`ifdef FP_DOT_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!aresetn || state != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  assign tmo = (wait_cnt == WW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next     = state;
    load     = 1'b0;
    ld_data  = mac_res_tdata;
    ld_trunc = 1'b0;
    ld_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) next = ISSUE;
      end
      ISSUE: next = WAIT;
      WAIT: begin
        if (mac_res_tvalid) begin
          if (last_q || count == CW'(MAX_LEN)) begin
            next     = OUT;
            load     = 1'b1;
            ld_trunc = !last_q;
          end else begin
            next = IDLE;
          end
        end else if (tmo) begin
          // Report the last good partial sum alongside the error.
          next    = OUT;
          load    = 1'b1;
          ld_data = acc;
          ld_err  = 1'b1;
        end
      end
      OUT: begin
        if (done) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      rst_done <= 1'b0;
      acc      <= FP_ZERO;
      count    <= '0;
      last_q   <= 1'b0;
      mac_a    <= FP_ZERO;
      mac_b    <= FP_ZERO;
      mac_c    <= FP_ZERO;
    end else begin
      rst_done <= 1'b1;
      if (accept) begin
        mac_a  <= in_a;
        mac_b  <= in_b;
        mac_c  <= acc;
        last_q <= in_last;
        count  <= count + CW'(1);
      end
      if (state == WAIT && mac_res_tvalid) begin
        acc <= mac_res_tdata;
      end
      if (done) begin
        acc    <= FP_ZERO;
        count  <= '0;
        last_q <= 1'b0;
      end
    end
  end

  fp_dot_out_reg u_out (
    .clk        (clk),
    .aresetn    (aresetn),
    .load       (load),
    .load_data  (ld_data),
    .load_trunc (ld_trunc),
    .load_err   (ld_err),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_trunc  (out_trunc),
    .out_err    (out_err),
    .done       (done)
  );

endmodule
